// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : door_pkg
//  Description : Shared constants for the door input-conditioning stage.
//                Channel indices, channel count and default timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package door_pkg;

    // Channel indices into the packed raw/debounced vectors
    localparam int CH_SEN = 0;
    localparam int CH_SE  = 1;
    localparam int CH_LA  = 2;
    localparam int CH_LC  = 3;
    localparam int NUM_CH = 4;

    // Default timing values
    localparam int c_DEB_CYCLES  = 16;
    localparam int c_HOLD_CYCLES = 1000;
    localparam int c_CNT_W       = 16;

    // One bit per conditioned channel
    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : door_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_chan
//  Description : One conditioned input channel: two-flop synchroniser
//                followed by a consecutive-cycle debounce counter.
//                The debounced level flips only after the synchronised
//                level has disagreed with it for DEB_CYCLES cycles in a row.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                i_raw      - raw asynchronous field input
//                o_deb      - registered debounced level
//                o_deb_next - value o_deb takes at the next clock edge
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
    import door_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEB_CYCLES,
    parameter int CNT_W      = c_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb,
    output logic o_deb_next
);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_deb_next;

    // The counter tracks how many consecutive cycles the synchronised level
    // has disagreed with the debounced level. Reaching DEB_CYCLES commits the
    // new level and restarts the count; any agreeing cycle restarts it too.
    always_comb begin
        w_cnt_next = '0;
        w_deb_next = r_deb;
        if (r_sync2 != r_deb) begin
            if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                w_deb_next = r_sync2;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_next;
            r_deb   <= w_deb_next;
        end
    end

    assign o_deb      = r_deb;
    assign o_deb_next = w_deb_next;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/door_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : door_input_cond
//  Description : Input-conditioning stage feeding the door-control FSM.
//                Synchronises and debounces the presence sensor, emergency
//                stop and both limit switches, stretches the presence sensor
//                after it clears, flags contradictory limit states and
//                reports when the outputs have settled after reset.
//  Build option: SE_LATCH_EN - when defined, se becomes a sticky latch that
//                is cleared by se_clr once the debounced stop is released.
//                When undefined, se follows the debounced stop directly.
//  Ports       : clk      - system clock
//                rst_n    - asynchronous active-low reset
//                raw_sen  - raw presence sensor
//                raw_se   - raw emergency stop
//                raw_la   - raw open-limit switch
//                raw_lc   - raw closed-limit switch
//                se_clr   - emergency latch clear (latched build only)
//                sen      - stretched, debounced sensor
//                se       - debounced (optionally latched) emergency stop
//                la / lc  - debounced limits, suppressed around a fault
//                sen_rise - one-cycle pulse on a rising sen
//                fault    - both limits debounced high
//                valid    - outputs settled since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module door_input_cond
    import door_pkg::*;
#(
    parameter int DEB_CYCLES  = c_DEB_CYCLES,
    parameter int HOLD_CYCLES = c_HOLD_CYCLES,
    parameter int CNT_W       = c_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_sen,
    input  logic raw_se,
    input  logic raw_la,
    input  logic raw_lc,
    input  logic se_clr,
    output logic sen,
    output logic se,
    output logic la,
    output logic lc,
    output logic sen_rise,
    output logic fault,
    output logic valid
);

    ch_vec_t w_raw;
    ch_vec_t w_deb;
    ch_vec_t w_deb_next;

    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_next;
    logic             w_sen;
    logic             r_sen_q;
    logic             r_sen_rise;
    logic             w_fault;
    logic             r_fault_q;
    logic [CNT_W-1:0] r_settle;
    logic             r_valid;

    assign w_raw[CH_SEN] = raw_sen;
    assign w_raw[CH_SE]  = raw_se;
    assign w_raw[CH_LA]  = raw_la;
    assign w_raw[CH_LC]  = raw_lc;

    // ------------------------------------------------------------------
    // Per-channel synchroniser and debounce
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        debounce_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_raw      (w_raw[gi]),
            .o_deb      (w_deb[gi]),
            .o_deb_next (w_deb_next[gi])
        );
    end

    // ------------------------------------------------------------------
    // Presence-sensor stretch
    // ------------------------------------------------------------------
    // The hold counter is loaded on the same edge that the debounced sensor
    // falls, so sen never shows a one-cycle gap between the two sources.
    // A re-rise clears the counter on the edge the debounced level returns.
    always_comb begin
        w_hold_next = r_hold;
        if (w_deb_next[CH_SEN]) begin
            w_hold_next = '0;
        end else if (w_deb[CH_SEN]) begin
            w_hold_next = CNT_W'(HOLD_CYCLES);
        end else if (r_hold != '0) begin
            w_hold_next = r_hold - 1'b1;
        end
    end

    assign w_sen = w_deb[CH_SEN] | (r_hold != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_sen_q    <= 1'b0;
            r_sen_rise <= 1'b0;
        end else begin
            r_hold     <= w_hold_next;
            r_sen_q    <= w_sen;
            r_sen_rise <= w_sen & ~r_sen_q;
        end
    end

    // ------------------------------------------------------------------
    // Limit switches and fault
    // ------------------------------------------------------------------
    // Limits are suppressed while the fault is present and for one more
    // cycle after it clears, so the FSM only sees a limit once the
    // contradiction is fully resolved.
    assign w_fault = w_deb[CH_LA] & w_deb[CH_LC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_q <= 1'b0;
        end else begin
            r_fault_q <= w_fault;
        end
    end

    // ------------------------------------------------------------------
    // Settle indicator
    // ------------------------------------------------------------------
    // Counts edges after reset release; valid is set on edge DEB_CYCLES+2
    // and the counter freezes from then on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_valid  <= 1'b0;
        end else if (!r_valid) begin
            r_settle <= r_settle + 1'b1;
            if (r_settle == CNT_W'(DEB_CYCLES + 1)) begin
                r_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Emergency stop
    // ------------------------------------------------------------------
`ifdef SE_LATCH_EN
    logic r_se_lat;

    // Sets together with the debounced stop; a clear request is honoured
    // only once the debounced stop is already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_se_lat <= 1'b0;
        end else if (w_deb_next[CH_SE]) begin
            r_se_lat <= 1'b1;
        end else if (se_clr && !w_deb[CH_SE]) begin
            r_se_lat <= 1'b0;
        end
    end

    assign se = r_se_lat;
`else
    logic w_unused_se;
    assign w_unused_se = se_clr | w_deb_next[CH_SE];
    assign se          = w_deb[CH_SE];
`endif

    // Limit channels only need their registered level
    logic w_unused_lim;
    assign w_unused_lim = w_deb_next[CH_LA] | w_deb_next[CH_LC];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sen      = w_sen;
    assign sen_rise = r_sen_rise;
    assign fault    = w_fault;
    assign la       = w_deb[CH_LA] & ~w_fault & ~r_fault_q;
    assign lc       = w_deb[CH_LC] & ~w_fault & ~r_fault_q;
    assign valid    = r_valid;

endmodule : door_input_cond
`default_nettype wire

// File: tb/tb_door_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_door_input_cond
//  Description : Self-checking bench for door_input_cond with DEB_CYCLES=4,
//                HOLD_CYCLES=10. A behavioural model built from sample
//                histories and timestamps predicts every output each cycle;
//                directed sequences add explicit timing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_door_input_cond;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_sen = 1'b0, raw_se = 1'b0, raw_la = 1'b0, raw_lc = 1'b0;
    logic se_clr = 1'b0;
    logic sen, se, la, lc, sen_rise, fault, valid;

    door_input_cond #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_sen  (raw_sen),
        .raw_se   (raw_se),
        .raw_la   (raw_la),
        .raw_lc   (raw_lc),
        .se_clr   (se_clr),
        .sen      (sen),
        .se       (se),
        .la       (la),
        .lc       (lc),
        .sen_rise (sen_rise),
        .fault    (fault),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rh[c] holds raw samples taken at each edge, bit0 newest. A sample
    // taken at edge t reaches the debounce comparison at edge t+2, so at any
    // edge the last DEB compared samples are bits [DEB+1:2]. The debounced
    // level flips when all of them disagree with it.
    logic [DEB+1:0] rh [4];
    logic           md [4];
    int             edges;
    int             fall_edge;
    logic           fall_valid;
    logic           sen_p1, sen_p2, fault_p, se_lat;
    logic e_sen, e_se, e_la, e_lc, e_rise, e_fault, e_valid;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            rh[c] = '0;
            md[c] = 1'b0;
        end
        edges = 0; fall_edge = 0; fall_valid = 1'b0;
        sen_p1 = 1'b0; sen_p2 = 1'b0; fault_p = 1'b0; se_lat = 1'b0;
        e_sen = 0; e_se = 0; e_la = 0; e_lc = 0; e_rise = 0; e_fault = 0; e_valid = 0;
    endtask

    task automatic model_step();
        logic [3:0]     r;
        logic [DEB-1:0] win;
        logic           old_sen, old_se;
        r = {raw_lc, raw_la, raw_se, raw_sen};
        edges++;
        old_sen = md[0];
        old_se  = md[1];
        for (int c = 0; c < 4; c++) begin
            rh[c] = {rh[c][DEB:0], r[c]};
            win   = rh[c][DEB+1:2];
            if (md[c] && win == '0)
                md[c] = 1'b0;
            else if (!md[c] && win == '1)
                md[c] = 1'b1;
        end
        if (old_sen && !md[0]) begin
            fall_edge  = edges;
            fall_valid = 1'b1;
        end
        if (md[0]) fall_valid = 1'b0;
        e_sen  = md[0] | (fall_valid && (edges - fall_edge) < HOLD);
        e_rise = sen_p1 & ~sen_p2;
        sen_p2 = sen_p1;
        sen_p1 = e_sen;
        e_fault = md[2] & md[3];
        e_la    = md[2] & ~e_fault & ~fault_p;
        e_lc    = md[3] & ~e_fault & ~fault_p;
        fault_p = e_fault;
`ifdef SE_LATCH_EN
        if (md[1]) se_lat = 1'b1;
        else if (se_clr && !old_se) se_lat = 1'b0;
        e_se = se_lat;
`else
        e_se = md[1];
`endif
        e_valid = (edges >= DEB + 2);
    endtask

    task automatic check_all();
        check_eq("sen",      sen,      e_sen);
        check_eq("se",       se,       e_se);
        check_eq("la",       la,       e_la);
        check_eq("lc",       lc,       e_lc);
        check_eq("sen_rise", sen_rise, e_rise);
        check_eq("fault",    fault,    e_fault);
        check_eq("valid",    valid,    e_valid);
    endtask

    // Inputs change just after a falling edge; tick advances one rising
    // edge, updates the model and compares on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_raw(input logic s, input logic e, input logic a, input logic c);
        raw_sen = s; raw_se = e; raw_la = a; raw_lc = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cd [4];
        int n_rise;
        int n_high;

        model_reset();
        #1;
        check_eq("reset_sen",   sen,   0);
        check_eq("reset_valid", valid, 0);
        check_all();

        // Reset release away from a rising edge; valid exactly on edge 6
        @(negedge clk);
        rst_n = 1'b1;
        ticks(DEB + 1);
        check_eq("valid_early", valid, 0);
        tick();
        check_eq("valid_edge6", valid, 1);

        // Open-limit latency and glitch rejection
        raw_la = 1'b1;
        ticks(DEB + 1);
        check_eq("la_before", la, 0);
        tick();
        check_eq("la_after", la, 1);
        raw_la = 1'b0;
        ticks(10);
        raw_la = 1'b1;
        ticks(3);
        raw_la = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("la_glitch", la, 0);
        end

        // Sensor stretch: single rise, full hold, then re-assert mid-hold
        n_rise = 0;
        raw_sen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_rise += int'(sen_rise);
        end
        check_eq("rise_once", n_rise, 1);
        raw_sen = 1'b0;
        ticks(DEB + 2);            // debounced sensor falls on this edge
        check_eq("sen_held", sen, 1);
        ticks(4);
        raw_sen = 1'b1;            // sampled on the edge the hold reaches 5
        n_rise = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("sen_nodip", sen, 1);
            n_rise += int'(sen_rise);
        end
        check_eq("rise_none", n_rise, 0);
        raw_sen = 1'b0;
        n_high = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            n_high += int'(sen);
        end
        check_eq("sen_high_cycles", n_high, DEB + 1 + HOLD);
        check_eq("sen_drained", sen, 0);

        // Fault: both limits high, then release the closed limit
        set_raw(0, 0, 1, 1);
        ticks(10);
        check_eq("fault_on", fault, 1);
        check_eq("fault_la", la, 0);
        check_eq("fault_lc", lc, 0);
        raw_lc = 1'b0;
        ticks(DEB + 1);
        check_eq("fault_hold", fault, 1);
        tick();
        check_eq("fault_off", fault, 0);
        check_eq("la_gap", la, 0);
        tick();
        check_eq("la_resume", la, 1);
        set_raw(0, 0, 0, 0);
        ticks(10);

        // Emergency stop
        raw_se = 1'b1;
        ticks(8);
        raw_se = 1'b0;
        check_eq("se_on", se, 1);
        ticks(10);
`ifdef SE_LATCH_EN
        check_eq("se_latched", se, 1);
        raw_se = 1'b1;
        ticks(8);
        se_clr = 1'b1;
        tick();
        se_clr = 1'b0;
        check_eq("se_clr_ignored", se, 1);
        raw_se = 1'b0;
        ticks(8);
        check_eq("se_still", se, 1);
        se_clr = 1'b1;
        tick();
        se_clr = 1'b0;
        check_eq("se_cleared", se, 0);
`else
        check_eq("se_follows", se, 0);
`endif

        // Randomised operation
        for (int c = 0; c < 4; c++) cd[c] = 1;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 4; c++) begin
                cd[c]--;
                if (cd[c] <= 0) begin
                    cd[c] = int'($urandom_range(1, 14));
                    case (c)
                        0: raw_sen = ~raw_sen;
                        1: raw_se  = ~raw_se;
                        2: raw_la  = ~raw_la;
                        default: raw_lc = ~raw_lc;
                    endcase
                end
            end
            se_clr = ($urandom_range(0, 5) == 0);
            tick();
        end
        se_clr = 1'b0;

        // Reset in the middle of a hold window (hold count 4)
        set_raw(1, 0, 0, 0);
        ticks(20);
        raw_sen = 1'b0;
        ticks(DEB + 2 + 6);
        check_eq("pre_reset_sen", sen, 1);
        raw_sen = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_sen",   sen,   0);
        check_eq("arst_valid", valid, 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(DEB + 1);
        check_eq("rst_sen_wait", sen, 0);
        tick();
        check_eq("rst_sen_back", sen, 1);
        ticks(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_door_input_cond
`default_nettype wire
